// File: rtl/lbp_pkg.sv
// Shared constants, FSM state type and border-address helper for the LBP host server.
package lbp_pkg;

    localparam int unsigned IMG_W   = 128;
    localparam int unsigned IMG_PIX = 16384;
    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned CNT_W   = 15;

    typedef enum logic [1:0] {
        StLoad,
        StServe,
        StDone
    } state_e;

    // Address is {row[6:0], col[6:0]}; border means first/last row or column.
    function automatic logic is_border(input logic [ADDR_W-1:0] addr);
        logic [6:0] row;
        logic [6:0] col;
        row = addr[ADDR_W-1:7];
        col = addr[6:0];
        return (row == 7'd0) || (row == 7'd127) || (col == 7'd0) || (col == 7'd127);
    endfunction

endpackage

// File: rtl/lbp_img_ram.sv
// 16384x8 single-port RAM with synchronous read; RdPortEn adds an always-enabled
// registered read port used for result readback.
module lbp_img_ram
    import lbp_pkg::*;
#(
    parameter bit RdPortEn = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [PIX_W-1:0]  wdata,
    input  logic              re,
    output logic [PIX_W-1:0]  rdata,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data
);

    logic [PIX_W-1:0] mem [IMG_PIX];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register holds its value between requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

    if (RdPortEn) begin : g_rd_port
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd_data <= '0;
            end else begin
                rd_data <= mem[rd_addr];
            end
        end
    end else begin : g_no_rd_port
        logic unused_rd_addr;
        assign unused_rd_addr = ^rd_addr;
        assign rd_data        = '0;
    end

endmodule

// File: rtl/lbp_host_server.sv
// LBP host server: preloads a 128x128 image, serves gray pixels, collects results.
// Define LBP_HOST_SERVER_BORDER_CHECK_EN to count result writes to border pixels.
module lbp_host_server
    import lbp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [PIX_W-1:0]  load_data,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic              gray_ready,
    output logic [PIX_W-1:0]  gray_data,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [PIX_W-1:0]  lbp_data,
    input  logic              finish,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    output logic              done,
    output logic [CNT_W-1:0]  wr_count
`ifdef LBP_HOST_SERVER_BORDER_CHECK_EN
    ,
    output logic [CNT_W-1:0]  err_count
`endif
);

    state_e            state_q;
    logic [ADDR_W-1:0] load_ptr_q;

    logic              img_we;
    logic [ADDR_W-1:0] img_addr;
    logic              gray_re;
    logic              res_we;
    logic [PIX_W-1:0]  img_unused_rd;
    logic [PIX_W-1:0]  res_unused_rdata;

    // Image RAM port is owned by the loader in LOAD and by the engine afterwards.
    assign img_we   = (state_q == StLoad) && load_valid;
    assign img_addr = (state_q == StLoad) ? load_ptr_q : gray_addr;
    assign gray_re  = gray_req && gray_ready;
    assign res_we   = (state_q == StServe) && lbp_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StLoad;
            load_ptr_q <= '0;
            gray_ready <= 1'b0;
            done       <= 1'b0;
            wr_count   <= '0;
`ifdef LBP_HOST_SERVER_BORDER_CHECK_EN
            err_count  <= '0;
`endif
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (load_valid) begin
                        load_ptr_q <= load_ptr_q + 1'b1;
                        if (load_ptr_q == ADDR_W'(IMG_PIX - 1)) begin
                            state_q    <= StServe;
                            gray_ready <= 1'b1;
                        end
                    end
                end
                StServe: begin
                    if (lbp_valid) begin
                        if (wr_count != CNT_W'(IMG_PIX)) begin
                            wr_count <= wr_count + 1'b1;
                        end
`ifdef LBP_HOST_SERVER_BORDER_CHECK_EN
                        if (is_border(lbp_addr) && (err_count != CNT_W'(IMG_PIX))) begin
                            err_count <= err_count + 1'b1;
                        end
`endif
                    end
                    // A write arriving with finish is still accepted above.
                    if (finish) begin
                        state_q    <= StDone;
                        gray_ready <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                StDone: begin
                end
                default: begin
                    state_q <= StLoad;
                end
            endcase
        end
    end

    lbp_img_ram #(
        .RdPortEn (1'b0)
    ) u_img_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (img_we),
        .addr    (img_addr),
        .wdata   (load_data),
        .re      (gray_re),
        .rdata   (gray_data),
        .rd_addr ('0),
        .rd_data (img_unused_rd)
    );

    lbp_img_ram #(
        .RdPortEn (1'b1)
    ) u_res_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (res_we),
        .addr    (lbp_addr),
        .wdata   (lbp_data),
        .re      (1'b0),
        .rdata   (res_unused_rdata),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_lbp_host_server.sv
// Self-checking bench for lbp_host_server; honours LBP_HOST_SERVER_BORDER_CHECK_EN.
module tb_lbp_host_server;
    import lbp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        gray_req;
    logic [13:0] gray_addr;
    logic        gray_ready;
    logic [7:0]  gray_data;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        finish;
    logic [13:0] rd_addr;
    logic [7:0]  rd_data;
    logic        done;
    logic [14:0] wr_count;
`ifdef LBP_HOST_SERVER_BORDER_CHECK_EN
    logic [14:0] err_count;
`endif

    always #5 clk = ~clk;

    lbp_host_server dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_ready (gray_ready),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .done       (done),
        .wr_count   (wr_count)
`ifdef LBP_HOST_SERVER_BORDER_CHECK_EN
        ,
        .err_count  (err_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: image contents, result contents, counters, last gray pixel.
    logic [7:0] img_m [IMG_PIX];
    logic [7:0] res_m [IMG_PIX];
    bit         written [IMG_PIX];
    int         wq [$];
    int         wr_exp = 0;
    int         err_exp = 0;
    logic [7:0] gray_exp = 8'h00;

    function automatic bit on_border(input int addr);
        int row = addr / 128;
        int col = addr % 128;
        return row == 0 || row == 127 || col == 0 || col == 127;
    endfunction

    // Model of one accepted result write in SERVE.
    function automatic void model_write(input int addr, input logic [7:0] data);
        res_m[addr] = data;
        if (!written[addr]) wq.push_back(addr);
        written[addr] = 1'b1;
        if (wr_exp < IMG_PIX) wr_exp++;
        if (on_border(addr) && err_exp < IMG_PIX) err_exp++;
    endfunction

    task automatic idle_inputs();
        load_valid = 0; load_data = 0; gray_req = 0; gray_addr = 0;
        lbp_valid = 0; lbp_addr = 0; lbp_data = 0; finish = 0; rd_addr = 0;
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if ({gray_ready, done, gray_data, rd_data, wr_count} !== '0) begin
            n_fail++;
            $display("FAIL %s: got ready=%b done=%b gray=%h rd=%h wr=%0d, required all zero",
                     name, gray_ready, done, gray_data, rd_data, wr_count);
        end
`ifdef LBP_HOST_SERVER_BORDER_CHECK_EN
        n_checks++;
        if (err_count !== 15'd0) begin
            n_fail++;
            $display("FAIL %s_err: got err_count=%0d, required 0", name, err_count);
        end
`endif
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Partial load of 5000 random pixels, then an asynchronous reset mid-LOAD.
    task automatic test_reset_mid_load();
        for (int i = 0; i < 5000; i++) begin
            load_valid = 1'b1;
            load_data  = 8'($urandom);
            @(negedge clk);
        end
        load_valid = 1'b0;
        n_checks++;
        if (gray_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_load_ready: got %b, required 0", gray_ready);
        end
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_mid_load");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Full load of pixel i = i[7:0] with ignored engine traffic riding along.
    task automatic test_load();
        for (int i = 0; i < IMG_PIX; i++) begin
            if (i == IMG_PIX - 1) begin
                n_checks++;
                if ({gray_ready, done, gray_data, wr_count} !== '0) begin
                    n_fail++;
                    $display("FAIL load_before_last: got ready=%b done=%b gray=%h wr=%0d, required 0",
                             gray_ready, done, gray_data, wr_count);
                end
            end
            load_valid = 1'b1;
            load_data  = 8'(i);
            img_m[i]   = 8'(i % 256);
            gray_req   = 1'b1;
            gray_addr  = 14'($urandom);
            lbp_valid  = 1'b1;
            lbp_addr   = 14'($urandom);
            lbp_data   = 8'($urandom);
            finish     = (i % 1000) == 7;
            @(negedge clk);
        end
        idle_inputs();
        n_checks++;
        if (gray_ready !== 1'b1 || done !== 1'b0 || wr_count !== 15'd0) begin
            n_fail++;
            $display("FAIL load_complete: got ready=%b done=%b wr=%0d, required ready=1 done=0 wr=0",
                     gray_ready, done, wr_count);
        end
    endtask

    task automatic test_gray_serve();
        int addrs [4] = '{'h81, 5, 6, 7};
        foreach (addrs[k]) begin
            gray_req  = 1'b1;
            gray_addr = 14'(addrs[k]);
            gray_exp  = img_m[addrs[k]];
            @(negedge clk);
            n_checks++;
            if (gray_data !== gray_exp) begin
                n_fail++;
                $display("FAIL gray_read_%0h: got %h, required %h", addrs[k], gray_data, gray_exp);
            end
        end
        gray_req  = 1'b0;
        gray_addr = 14'h0200;
        @(negedge clk);
        n_checks++;
        if (gray_data !== gray_exp) begin
            n_fail++;
            $display("FAIL gray_hold: got %h, required %h", gray_data, gray_exp);
        end
    endtask

    task automatic drive_write(input int addr, input logic [7:0] data);
        lbp_valid = 1'b1;
        lbp_addr  = 14'(addr);
        lbp_data  = data;
        model_write(addr, data);
        @(negedge clk);
        lbp_valid = 1'b0;
    endtask

    task automatic test_lbp_write();
        logic [7:0] vals [3] = '{8'hA5, 8'h11, 8'h22};
        foreach (vals[k]) begin
            drive_write('h81, vals[k]);
            rd_addr = 14'h0081;
            @(negedge clk);
            n_checks++;
            if (rd_data !== res_m['h81] || wr_count !== 15'(wr_exp)) begin
                n_fail++;
                $display("FAIL lbp_write_%0d: got rd=%h wr=%0d, required rd=%h wr=%0d",
                         k, rd_data, wr_count, res_m['h81], wr_exp);
            end
        end
    endtask

    task automatic test_border();
`ifdef LBP_HOST_SERVER_BORDER_CHECK_EN
        int e0 = err_exp;
        int w0 = wr_exp;
        drive_write('h0000, 8'h01);
        drive_write('h007F, 8'h02);
        drive_write('h0081, 8'h03);
        n_checks++;
        if (err_count !== 15'(e0 + 2) || wr_count !== 15'(w0 + 3)) begin
            n_fail++;
            $display("FAIL border_count: got err=%0d wr=%0d, required err=%0d wr=%0d",
                     err_count, wr_count, e0 + 2, w0 + 3);
        end
        rd_addr = 14'h007F;
        @(negedge clk);
        n_checks++;
        if (rd_data !== 8'h02) begin
            n_fail++;
            $display("FAIL border_stored: got %h, required 02", rd_data);
        end
`endif
    endtask

    // Mixed random gray reads, result writes, readbacks and ignored loads.
    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            int ga;
            int la;
            int ra;
            bit rd_chk;
            logic [7:0] rd_exp;
            logic [7:0] ld;
            gray_req   = 1'($urandom);
            ga         = int'($urandom % IMG_PIX);
            gray_addr  = 14'(ga);
            load_valid = 1'($urandom);
            load_data  = 8'($urandom);
            lbp_valid  = 1'($urandom);
            la = (wq.size() > 0 && ($urandom % 2) == 1) ? wq[$urandom_range(wq.size() - 1)]
                                                         : int'($urandom % IMG_PIX);
            ld         = 8'($urandom);
            lbp_addr   = 14'(la);
            lbp_data   = ld;
            ra         = wq[$urandom_range(wq.size() - 1)];
            rd_addr    = 14'(ra);
            rd_chk     = !(lbp_valid && la == ra);
            rd_exp     = res_m[ra];
            if (gray_req) gray_exp = img_m[ga];
            if (lbp_valid) model_write(la, ld);
            @(negedge clk);
            n_checks++;
            if (gray_data !== gray_exp || wr_count !== 15'(wr_exp)) begin
                n_fail++;
                $display("FAIL random_%0d: got gray=%h wr=%0d, required gray=%h wr=%0d",
                         n, gray_data, wr_count, gray_exp, wr_exp);
            end
            if (rd_chk) begin
                n_checks++;
                if (rd_data !== rd_exp) begin
                    n_fail++;
                    $display("FAIL random_rd_%0d: got %h, required %h", n, rd_data, rd_exp);
                end
            end
`ifdef LBP_HOST_SERVER_BORDER_CHECK_EN
            n_checks++;
            if (err_count !== 15'(err_exp)) begin
                n_fail++;
                $display("FAIL random_err_%0d: got %0d, required %0d", n, err_count, err_exp);
            end
`endif
        end
        idle_inputs();
    endtask

    task automatic test_finish();
        lbp_valid = 1'b1;
        lbp_addr  = 14'h0100;
        lbp_data  = 8'h3C;
        finish    = 1'b1;
        model_write('h100, 8'h3C);
        @(negedge clk);
        lbp_valid = 1'b0;
        finish    = 1'b0;
        n_checks++;
        if (done !== 1'b1 || gray_ready !== 1'b0 || wr_count !== 15'(wr_exp)) begin
            n_fail++;
            $display("FAIL finish_write: got done=%b ready=%b wr=%0d, required done=1 ready=0 wr=%0d",
                     done, gray_ready, wr_count, wr_exp);
        end
        lbp_valid = 1'b1;
        lbp_addr  = 14'h0200;
        lbp_data  = 8'hEE;
        rd_addr   = 14'h0100;
        @(negedge clk);
        lbp_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rd_data !== 8'h3C || wr_count !== 15'(wr_exp) || done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_state: got rd=%h wr=%0d done=%b, required rd=3c wr=%0d done=1",
                     rd_data, wr_count, done, wr_exp);
        end
`ifdef LBP_HOST_SERVER_BORDER_CHECK_EN
        n_checks++;
        if (err_count !== 15'(err_exp)) begin
            n_fail++;
            $display("FAIL done_err: got %0d, required %0d", err_count, err_exp);
        end
`endif
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_after_done");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_reset_mid_load();
        test_load();
        test_gray_serve();
        test_lbp_write();
        test_border();
        test_random();
        test_finish();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
